// File: rtl/he_hssi_tx_buf_pkg.sv
// he_hssi_tx_buf_pkg: shared beat type, write FSM states and defaults for the HSSI TX packet buffer
package he_hssi_tx_buf_pkg;
  localparam int BEAT_DATA_W       = 64;
  localparam int BEAT_EMPTY_W      = 3;
  localparam int DEF_DEPTH         = 512;
  localparam int DEF_MAX_PKTS      = 32;
  localparam int DEF_MAX_PKT_WORDS = 256;
  typedef struct packed {
    logic [BEAT_DATA_W-1:0]  data;
    logic                    sop;
    logic                    eop;
    logic [BEAT_EMPTY_W-1:0] empty;
    logic                    error;
  } tx_beat_t;
  typedef enum logic [1:0] {IDLE, WR, DISCARD} wr_state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return &c ? c : c + 32'd1;
  endfunction
endpackage

// File: rtl/he_hssi_sdp_ram.sv
// he_hssi_sdp_ram: single-clock simple dual-port RAM with one-cycle registered read
module he_hssi_sdp_ram #(
  parameter int W     = 72,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/he_hssi_tx_pkt_buffer.sv
// he_hssi_tx_pkt_buffer: store-and-forward Avalon-ST TX buffer that releases only complete, clean packets
module he_hssi_tx_pkt_buffer
  import he_hssi_tx_buf_pkg::*;
#(
  parameter int DATA_W        = BEAT_DATA_W,
  parameter int EMPTY_W       = BEAT_EMPTY_W,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int MAX_PKTS      = DEF_MAX_PKTS,
  parameter int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS,
  parameter bit DROP_ON_ERROR = 1'b1
) (
  input  logic                   tx_clk_156,
  input  logic                   tx_rst_n,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_valid,
  input  logic                   i_sop,
  input  logic                   i_eop,
  input  logic [EMPTY_W-1:0]     i_empty,
  input  logic                   i_error,
  output logic                   o_ready,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_valid,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic [EMPTY_W-1:0]     o_empty,
  output logic                   o_error,
  input  logic                   i_ready,
  input  logic                   i_clr_stats,
  output logic [$clog2(DEPTH):0] o_fill_level,
  output logic [31:0]            o_pkt_in_cnt,
  output logic [31:0]            o_pkt_out_cnt,
  output logic [31:0]            o_drop_err_cnt,
  output logic [31:0]            o_drop_ovs_cnt,
  output logic [31:0]            o_drop_fmt_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(MAX_PKTS);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [AW:0]   A1 = (AW+1)'(1);
  localparam logic [PW:0]   P1 = (PW+1)'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  wr_state_e state, state_n;
  logic [AW:0] wr_ptr, wr_ptr_n, com_ptr, com_ptr_n, rel_ptr, rel_ptr_n, rd_ptr, wr_addr;
  logic [CW-1:0] cnt, cnt_n;
  logic rdy_en, acc, start_beat, cont_beat, ovs, wr_en, end_pkt, err_drop, commit, fmt_drop, ram_full;
  logic [AW:0] pf_mem [MAX_PKTS];
  logic [PW:0] pf_wp, pf_rp, pf_cnt;
  tx_beat_t wr_beat, rd_beat, out_beat;
  tx_beat_t sk_mem [2];
  logic [1:0] occ;
  logic sk_wp, sk_rp, rd_vld, issue, pop, pkt_done;
  logic [31:0] stat [5];
  logic [4:0] stat_inc;
  // com_ptr is both the committed boundary and the start of the packet being written
  assign ram_full = (wr_ptr[AW] != rel_ptr[AW]) && (wr_ptr[AW-1:0] == rel_ptr[AW-1:0]);
  assign pf_cnt   = pf_wp - pf_rp;
  assign o_ready  = rdy_en && (state == DISCARD || (!ram_full && !pf_cnt[PW]));
  assign acc      = i_valid && o_ready;
  always_comb begin
    start_beat = acc && i_sop && state != DISCARD;
    cont_beat  = acc && !i_sop && state == WR;
    ovs        = cont_beat && cnt == CW'(MAX_PKT_WORDS);
    wr_en      = start_beat || (cont_beat && !ovs);
    wr_addr    = start_beat ? com_ptr : wr_ptr;
    end_pkt    = wr_en && i_eop;
    err_drop   = end_pkt && i_error && DROP_ON_ERROR;
    commit     = end_pkt && !err_drop;
    fmt_drop   = acc && ((state == IDLE && !i_sop) || (state == WR && i_sop));
    wr_ptr_n   = (err_drop || ovs) ? com_ptr : wr_en ? wr_addr + A1 : wr_ptr;
    com_ptr_n  = commit ? wr_addr + A1 : com_ptr;
    cnt_n      = start_beat ? C1 : wr_en ? cnt + C1 : cnt;
    state_n    = !acc ? state : i_eop ? IDLE : wr_en ? WR : DISCARD;
    wr_beat.data  = i_data;
    wr_beat.sop   = i_sop;
    wr_beat.eop   = i_eop;
    wr_beat.empty = i_empty;
    wr_beat.error = !DROP_ON_ERROR && i_error && i_eop;
  end
  always_ff @(posedge tx_clk_156)
    state <= !tx_rst_n ? IDLE : state_n;
  he_hssi_sdp_ram #(.W($bits(tx_beat_t)), .DEPTH(DEPTH)) u_ram (
    .clk   (tx_clk_156),
    .we    (wr_en),
    .waddr (wr_addr[AW-1:0]),
    .wdata (wr_beat),
    .re    (issue),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_beat)
  );
  // Fetch only committed beats, keeping RAM-in-flight plus skid occupancy within two entries
  assign out_beat  = sk_mem[sk_rp];
  assign o_valid   = occ != 2'd0;
  assign pop       = o_valid && i_ready;
  assign pkt_done  = pop && out_beat.eop;
  assign issue     = (rd_ptr != com_ptr) && (({1'b0, occ} + {2'b0, rd_vld} - {2'b0, pop}) < 3'd2);
  assign rel_ptr_n = !pkt_done ? rel_ptr : pf_cnt > P1 ? pf_mem[pf_rp[PW-1:0] + PW'(1)] : com_ptr;
  always_ff @(posedge tx_clk_156)
    if (commit) pf_mem[pf_wp[PW-1:0]] <= wr_addr;
  always_ff @(posedge tx_clk_156) begin
    if (!tx_rst_n) begin
      wr_ptr  <= '0;
      com_ptr <= '0;
      rel_ptr <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      rdy_en  <= 1'b0;
      pf_wp   <= '0;
      pf_rp   <= '0;
      rd_vld  <= 1'b0;
      occ     <= '0;
      sk_wp   <= 1'b0;
      sk_rp   <= 1'b0;
      sk_mem  <= '{default: '0};
    end else begin
      wr_ptr  <= wr_ptr_n;
      com_ptr <= com_ptr_n;
      rel_ptr <= rel_ptr_n;
      cnt     <= cnt_n;
      rdy_en  <= 1'b1;
      pf_wp   <= commit ? pf_wp + P1 : pf_wp;
      pf_rp   <= pkt_done ? pf_rp + P1 : pf_rp;
      rd_vld  <= issue;
      rd_ptr  <= issue ? rd_ptr + A1 : rd_ptr;
      occ     <= occ + {1'b0, rd_vld} - {1'b0, pop};
      sk_rp   <= sk_rp ^ pop;
      sk_wp   <= sk_wp ^ rd_vld;
      if (rd_vld) sk_mem[sk_wp] <= rd_beat;
    end
  end
  assign stat_inc = {fmt_drop, ovs, err_drop, pkt_done, commit};
  always_ff @(posedge tx_clk_156)
    for (int k = 0; k < 5; k++)
      stat[k] <= (!tx_rst_n || i_clr_stats) ? '0 : stat_inc[k] ? sat_inc(stat[k]) : stat[k];
  assign o_data         = out_beat.data;
  assign o_sop          = out_beat.sop;
  assign o_eop          = out_beat.eop;
  assign o_empty        = out_beat.empty;
  assign o_error        = out_beat.error;
  assign o_fill_level   = wr_ptr - rel_ptr;
  assign o_pkt_in_cnt   = stat[0];
  assign o_pkt_out_cnt  = stat[1];
  assign o_drop_err_cnt = stat[2];
  assign o_drop_ovs_cnt = stat[3];
  assign o_drop_fmt_cnt = stat[4];
endmodule

// File: tb/tb_he_hssi_tx_pkt_buffer.sv
// tb_he_hssi_tx_pkt_buffer: directed self-checking bench for the HSSI TX packet buffer
module tb_he_hssi_tx_pkt_buffer;
  logic tx_clk_156, tx_rst_n;
  logic [63:0] i_data, o_data;
  logic i_valid, i_sop, i_eop, i_error, o_ready, o_valid, o_sop, o_eop, o_error, i_ready, i_clr_stats;
  logic [2:0] i_empty, o_empty;
  logic [9:0] o_fill_level;
  logic [31:0] o_pkt_in_cnt, o_pkt_out_cnt, o_drop_err_cnt, o_drop_ovs_cnt, o_drop_fmt_cnt;
  int n_checks = 0, n_fails = 0, cyc = 0, stalls = 0, acc_cyc = 0, sop_cyc = 0;
  bit sop_seen = 0;
  logic [69:0] rx_q[$], exp_q[$];
  int rx_cyc[$];

  he_hssi_tx_pkt_buffer dut (
    .tx_clk_156(tx_clk_156), .tx_rst_n(tx_rst_n),
    .i_data(i_data), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
    .i_empty(i_empty), .i_error(i_error), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop),
    .o_empty(o_empty), .o_error(o_error), .i_ready(i_ready),
    .i_clr_stats(i_clr_stats), .o_fill_level(o_fill_level),
    .o_pkt_in_cnt(o_pkt_in_cnt), .o_pkt_out_cnt(o_pkt_out_cnt),
    .o_drop_err_cnt(o_drop_err_cnt), .o_drop_ovs_cnt(o_drop_ovs_cnt),
    .o_drop_fmt_cnt(o_drop_fmt_cnt)
  );

  initial tx_clk_156 = 1'b0;
  always #5 tx_clk_156 = ~tx_clk_156;
  always @(posedge tx_clk_156) cyc <= cyc + 1;

  always @(negedge tx_clk_156) begin
    if (o_valid && o_sop && !sop_seen) begin
      sop_seen = 1;
      sop_cyc = cyc;
    end
    if (o_valid && i_ready) begin
      rx_q.push_back({o_error, o_empty, o_sop, o_eop, o_data});
      rx_cyc.push_back(cyc);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [63:0] d, input logic s, input logic e, input logic [2:0] em,
                     input logic er, input logic clr);
    int n = 0;
    i_valid = 1; i_data = d; i_sop = s; i_eop = e; i_empty = em; i_error = er; i_clr_stats = clr;
    while (!o_ready && n < 3000) begin
      @(posedge tx_clk_156); #1;
      n++;
    end
    stalls += n;
    if (n == 3000) begin
      check("put_ready", o_ready, 1'b1);
      i_valid = 0; i_clr_stats = 0;
      return;
    end
    acc_cyc = cyc;
    @(posedge tx_clk_156); #1;
    i_valid = 0; i_clr_stats = 0;
  endtask

  task automatic send_pkt(input int id, input int n, input logic [2:0] em, input logic er,
                          input bit keep, input bit clr);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {16'(id), 16'(i), 32'hC0DE_0000 + 32'(i)};
      put(d, i == 0, i == n - 1, (i == n - 1) ? em : 3'd0, (i == n - 1) ? er : 1'b0, clr && i == n - 1);
      if (keep) exp_q.push_back({1'b0, (i == n - 1) ? em : 3'd0, i == 0, i == n - 1, d});
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    repeat (10) @(posedge tx_clk_156);
    #1;
    while ((rx_q.size() < exp_q.size() || o_fill_level != 10'd0) && n < 5000) begin
      @(posedge tx_clk_156); #1;
      n++;
    end
    check({tag, "_beats"}, rx_q.size(), exp_q.size());
    check({tag, "_fill"}, o_fill_level, 10'd0);
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic flush();
    rx_q.delete();
    exp_q.delete();
    rx_cyc.delete();
  endtask

  initial begin
    tx_rst_n = 0; i_valid = 0; i_data = '0; i_sop = 0; i_eop = 0; i_empty = '0; i_error = 0;
    i_ready = 1; i_clr_stats = 0;
    repeat (3) @(posedge tx_clk_156);
    #1;
    check("rst_ready", o_ready, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_fill", o_fill_level, 10'd0);
    check("rst_data", {o_data, o_sop, o_eop, o_empty, o_error}, '0);
    check("rst_cnts", {o_pkt_in_cnt, o_pkt_out_cnt, o_drop_err_cnt, o_drop_ovs_cnt, o_drop_fmt_cnt}, '0);
    tx_rst_n = 1;
    check("rdy_before_edge", o_ready, 1'b0);
    @(posedge tx_clk_156); #1;
    check("rdy_after_edge", o_ready, 1'b1);

    sop_seen = 0;
    send_pkt(1, 8, 3'd4, 1'b0, 1, 0);
    drain("p8");
    check("p8_latency", sop_cyc - acc_cyc, 3);
    check("p8_contig", rx_cyc.size() == 8 ? rx_cyc[7] - rx_cyc[0] : -1, 7);
    check("p8_in", o_pkt_in_cnt, 1);
    check("p8_out", o_pkt_out_cnt, 1);
    flush();

    send_pkt(2, 1, 3'd5, 1'b0, 1, 0);
    send_pkt(3, 64, 3'd2, 1'b0, 1, 0);
    drain("p1_64");
    check("p1_64_out", o_pkt_out_cnt, 3);
    flush();

    send_pkt(4, 4, 3'd2, 1'b1, 0, 0);
    drain("err");
    check("err_cnt", o_drop_err_cnt, 1);
    check("err_in", o_pkt_in_cnt, 3);
    flush();

    begin
      int s0 = stalls;
      send_pkt(5, 300, 3'd0, 1'b0, 0, 0);
      check("ovs_no_stall", stalls - s0, 0);
      check("ovs_cnt", o_drop_ovs_cnt, 1);
    end
    send_pkt(6, 10, 3'd7, 1'b0, 1, 0);
    drain("ovs_next");
    check("ovs_next_in", o_pkt_in_cnt, 4);
    flush();

    i_ready = 0;
    fork
      for (int p = 0; p < 40; p++) send_pkt(100 + p, 16, 3'(p % 8), 1'b0, 1, 0);
      begin
        int n = 0;
        while (o_pkt_in_cnt < 36 && n < 3000) begin
          @(posedge tx_clk_156); #1;
          n++;
        end
        repeat (20) @(posedge tx_clk_156);
        #1;
        check("full_ready", o_ready, 1'b0);
        check("full_in", o_pkt_in_cnt, 36);
        check("full_fill", o_fill_level, 10'd512);
        i_ready = 1;
      end
    join
    drain("burst");
    check("burst_in", o_pkt_in_cnt, 44);
    check("burst_out", o_pkt_out_cnt, 44);
    check("burst_drops", {o_drop_err_cnt, o_drop_ovs_cnt, o_drop_fmt_cnt}, {32'd1, 32'd1, 32'd0});
    flush();

    send_pkt(30, 2, 3'd1, 1'b0, 1, 1);
    check("clr_in", o_pkt_in_cnt, 0);
    check("clr_drops", {o_drop_err_cnt, o_drop_ovs_cnt}, '0);
    drain("clr");
    check("clr_out", o_pkt_out_cnt, 1);
    flush();

    i_ready = 0;
    send_pkt(40, 16, 3'd0, 1'b0, 0, 0);
    repeat (6) @(posedge tx_clk_156);
    #1;
    for (int i = 0; i < 5; i++) put(64'(i), i == 0, 1'b0, 3'd0, 1'b0, 1'b0);
    tx_rst_n = 0;
    @(posedge tx_clk_156); #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_ready", o_ready, 1'b0);
    check("mid_rst_fill", o_fill_level, 10'd0);
    check("mid_rst_data", {o_data, o_sop, o_eop, o_empty, o_error}, '0);
    check("mid_rst_cnts", {o_pkt_in_cnt, o_pkt_out_cnt, o_drop_err_cnt, o_drop_ovs_cnt, o_drop_fmt_cnt}, '0);
    repeat (2) @(posedge tx_clk_156);
    #1;
    tx_rst_n = 1;
    i_ready = 1;
    flush();
    @(posedge tx_clk_156); #1;
    send_pkt(41, 8, 3'd3, 1'b0, 1, 0);
    drain("post_rst");
    check("post_rst_cnts", {o_pkt_in_cnt, o_pkt_out_cnt, o_drop_err_cnt, o_drop_ovs_cnt, o_drop_fmt_cnt},
          {32'd1, 32'd1, 32'd0, 32'd0, 32'd0});
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
